// File: rtl/fma_pkg.sv
// Shared constants and types for the FMA issue controller.
package fma_pkg;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned EXP_WIDTH = 8;
  localparam int unsigned SIG_WIDTH = 23;

  // Rounding-mode encodings; both 10 and 11 select round-to-nearest-even.
  localparam logic [1:0] RND_RZ  = 2'b00;
  localparam logic [1:0] RND_RN  = 2'b01;
  localparam logic [1:0] RND_RNE = 2'b10;

  // Bit positions inside the 3-bit {nan, inf, zero} flag vector.
  localparam int unsigned FLAG_NAN  = 2;
  localparam int unsigned FLAG_INF  = 1;
  localparam int unsigned FLAG_ZERO = 0;

  localparam logic [WIDTH-1:0] code_NaN  = 32'h7FC0_0000;
  localparam logic [WIDTH-1:0] code_PINF = 32'h7F80_0000;
  localparam logic [WIDTH-1:0] code_NINF = 32'hFF80_0000;

  typedef enum logic [0:0] {
    OpEmpty,
    OpHeld
  } op_state_e;

endpackage

// File: rtl/fma_result_fifo.sv
// In-order result buffer; pointers wrap modulo DEPTH, synchronous clear.
module fma_result_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned DW    = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_clr,
  input  logic                         i_push,
  input  logic [DW-1:0]                i_wdata,
  input  logic                         i_pop,
  output logic [DW-1:0]                o_rdata,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [PW-1:0] w_wptr_nxt, w_rptr_nxt;
  logic [CW-1:0] r_count;
  logic          w_push, w_pop;

  // Guard against overflow/underflow; a push into a full buffer is legal only alongside a pop.
  always_comb begin
    w_pop      = i_pop & (r_count != '0);
    w_push     = i_push & ((r_count != CW'(DEPTH)) | w_pop);
    w_wptr_nxt = (r_wptr == PW'(DEPTH-1)) ? '0 : r_wptr + PW'(1);
    w_rptr_nxt = (r_rptr == PW'(DEPTH-1)) ? '0 : r_rptr + PW'(1);
  end

  // Pointer and occupancy state.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= w_wptr_nxt;
      if (w_pop)  r_rptr <= w_rptr_nxt;
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  // Payload storage; contents are only observed through a valid head.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/fma_issue_ctrl.sv
// Issue controller for an external registered FMA core: one op slot, fixed
// two-cycle issue-to-capture latency, and an in-order result buffer.
module fma_issue_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic [1:0]       in_rnd,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic [WIDTH-1:0] fma_a,
  output logic [WIDTH-1:0] fma_b,
  output logic [WIDTH-1:0] fma_c,
  output logic [1:0]       fma_rnd,
  output logic             fma_enable,
  input  logic [WIDTH-1:0] fma_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [2:0]       out_flags,
  output logic             busy
);
  import fma_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned DW = WIDTH + TAG_W + 3;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  op_state_e            r_state, w_state_d;
  logic                 w_op_valid;
  logic [WIDTH-1:0]     r_op_a, r_op_b, r_op_c;
  logic [1:0]           r_op_rnd;
  logic [TAG_W-1:0]     r_op_tag;
  logic                 r_inflight;
  logic [TAG_W-1:0]     r_inf_tag;
  logic                 w_accept, w_issue, w_pop, w_push, w_out_valid;
  logic [CW-1:0]        w_count;
  logic [CW:0]          w_occ;
  logic [EXP_WIDTH-1:0] w_exp;
  logic [WIDTH-EXP_WIDTH-2:0] w_man;
  logic [2:0]           w_flags;
  logic [DW-1:0]        w_wdata, w_rdata;

  assign w_op_valid  = (r_state == OpHeld);
  assign w_out_valid = (w_count != '0);
  assign w_pop       = w_out_valid & out_ready;

  // Issue only if the result is guaranteed a buffer slot once it lands.
  always_comb begin
    w_occ    = {1'b0, w_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};
    w_issue  = w_op_valid & ~flush & ~RST & (w_occ < DEPTH_W);
    in_ready = ~RST & ~flush & (~w_op_valid | w_issue);
    w_accept = in_valid & in_ready;
  end

  // Op-slot next state: refill on issue+accept keeps the slot held.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      OpEmpty: if (w_accept) w_state_d = OpHeld;
      OpHeld:  if (w_issue && !w_accept) w_state_d = OpEmpty;
      default: w_state_d = OpEmpty;
    endcase
    if (flush) w_state_d = OpEmpty;
  end

  // Op-slot state register.
  always_ff @(posedge clk) begin
    if (RST) r_state <= OpEmpty;
    else     r_state <= w_state_d;
  end

  // Op payload register, loaded on accept.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_op_c   <= '0;
      r_op_rnd <= '0;
      r_op_tag <= '0;
    end else if (w_accept) begin
      r_op_a   <= in_a;
      r_op_b   <= in_b;
      r_op_c   <= in_c;
      r_op_rnd <= in_rnd;
      r_op_tag <= in_tag;
    end
  end

  // Tracks the op whose result the core presents on the next edge.
  always_ff @(posedge clk) begin
    if (RST || flush) begin
      r_inflight <= 1'b0;
      r_inf_tag  <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_inf_tag <= r_op_tag;
    end
  end

  // Classify the core result as it is captured.
  always_comb begin
    w_exp              = fma_out[WIDTH-2 -: EXP_WIDTH];
    w_man              = fma_out[WIDTH-EXP_WIDTH-2:0];
    w_flags            = '0;
    w_flags[FLAG_NAN]  = (&w_exp) & (|w_man);
    w_flags[FLAG_INF]  = (&w_exp) & ~(|w_man);
    w_flags[FLAG_ZERO] = ~(|fma_out[WIDTH-2:0]);
  end

  assign w_push  = r_inflight & ~flush;
  assign w_wdata = {r_inf_tag, w_flags, fma_out};

  fma_result_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_result_fifo (
    .i_clk   (clk),
    .i_rst   (RST),
    .i_clr   (flush),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_count (w_count)
  );

  // Head drives the outputs; zeroed when empty so stale entries never leak.
  always_comb begin
    out_valid                        = w_out_valid;
    {out_tag, out_flags, out_result} = w_out_valid ? w_rdata : '0;
    busy                             = w_op_valid | r_inflight | w_out_valid;
    fma_a                            = r_op_a;
    fma_b                            = r_op_b;
    fma_c                            = r_op_c;
    fma_rnd                          = r_op_rnd;
    fma_enable                       = w_issue;
  end

endmodule
